// File: rtl/cursor_pointer.sv
// cursor_pointer: button-driven square pointer for the VGA game display.
// Four active-low buttons move the pointer. Diagonal moves are allowed.
// A held button moves once, then pauses, then auto-repeats.
// Edges clamp by default. Define CURSOR_WRAP_EN to wrap at the edges instead.
// Each pixel clock the block registers whether (row, col) is inside the pointer.
module cursor_pointer #(
    parameter int X_INIT       = 120,
    parameter int Y_INIT       = 40,
    parameter int STEP         = 10,
    parameter int SIZE         = 10,
    parameter int X_MAX        = 640,
    parameter int Y_MAX        = 480,
    parameter int TICK_DIV     = 2000000,
    parameter int REPEAT_TICKS = 8,
    parameter int COLOR        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic [8:0] row,
    input  logic [9:0] col,
    output logic       cursor_here,
    output logic [7:0] color_index,
    output logic [9:0] x_pos,
    output logic [8:0] y_pos,
    output logic       moved
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] X_LIM  = 11'(X_MAX - SIZE);
    localparam logic signed [10:0] Y_LIM  = 11'(Y_MAX - SIZE);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPEAT} state_t;

    // Button order: 0 = up, 1 = down, 2 = left, 3 = right.
    logic [3:0] btn_raw;
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic [3:0] pressed;

    assign btn_raw = {right, left, down, up};
    assign pressed = ~sync2_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            // Two-flop synchroniser per button; reset leaves it in the released state.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg[gi] <= 1'b1;
                    sync2_reg[gi] <= 1'b1;
                end else begin
                    sync1_reg[gi] <= btn_raw[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    logic [TW-1:0] tick_cnt_reg;
    logic          tick;

    assign tick = (tick_cnt_reg == TW'(TICK_DIV - 1));

    // Free-running movement tick divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     tick_cnt_reg <= '0;
        else if (tick) tick_cnt_reg <= '0;
        else           tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end

    // An axis moves only when exactly one of its two buttons is held.
    logic x_dec, x_inc, y_dec, y_inc, any_dir;
    assign x_dec   = pressed[2] & ~pressed[3];
    assign x_inc   = pressed[3] & ~pressed[2];
    assign y_dec   = pressed[0] & ~pressed[1];
    assign y_inc   = pressed[1] & ~pressed[0];
    assign any_dir = x_dec | x_inc | y_dec | y_inc;

    // One step on one axis, with clamping or wrap-around at the edges.
    function automatic logic signed [10:0] axis_move(
        input logic signed [10:0] pos,
        input logic               inc,
        input logic               dec,
        input logic signed [10:0] lim
    );
        logic signed [10:0] r;
        r = pos;
        if (dec) begin
            if (pos < STEP_S)
`ifdef CURSOR_WRAP_EN
                r = pos + lim + 11'sd1 - STEP_S;
`else
                r = 11'sd0;
`endif
            else
                r = pos - STEP_S;
        end else if (inc) begin
            if (pos + STEP_S > lim)
`ifdef CURSOR_WRAP_EN
                r = pos + STEP_S - (lim + 11'sd1);
`else
                r = lim;
`endif
            else
                r = pos + STEP_S;
        end
        return r;
    endfunction

    state_t             state_reg, state_next;
    logic [RW-1:0]      rcnt_reg, rcnt_next;
    logic [9:0]         x_reg, x_next;
    logic [8:0]         y_reg, y_next;
    logic               moved_reg, moved_next;
    logic               do_move;
    logic signed [10:0] x_mv, y_mv;

    assign x_mv = axis_move({1'b0, x_reg}, x_inc, x_dec, X_LIM);
    assign y_mv = axis_move({2'b0, y_reg}, y_inc, y_dec, Y_LIM);

    // Repeat FSM next state: act only on ticks, use the current dx/dy for every move.
    always_comb begin
        state_next = state_reg;
        rcnt_next  = rcnt_reg;
        do_move    = 1'b0;
        if (tick) begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_dir) begin
                        do_move    = 1'b1;
                        rcnt_next  = '0;
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!any_dir) begin
                        state_next = ST_IDLE;
                    end else begin
                        rcnt_next = rcnt_reg + RW'(1);
                        if (rcnt_reg + RW'(1) == RW'(REPEAT_TICKS)) begin
                            do_move    = 1'b1;
                            state_next = ST_REPEAT;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (any_dir) do_move    = 1'b1;
                    else         state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Position update; moved flags only a real change of position.
    always_comb begin
        x_next     = do_move ? x_mv[9:0] : x_reg;
        y_next     = do_move ? y_mv[8:0] : y_reg;
        moved_next = do_move && ((x_mv[9:0] != x_reg) || (y_mv[8:0] != y_reg));
    end

    // FSM, counter and position registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            rcnt_reg  <= '0;
            x_reg     <= 10'(X_INIT);
            y_reg     <= 9'(Y_INIT);
            moved_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rcnt_reg  <= rcnt_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            moved_reg <= moved_next;
        end
    end

    // Hit test against the current position; sums are one bit wider than the operands.
    logic [10:0] x_end;
    logic [9:0]  y_end;
    logic        hit;
    assign x_end = {1'b0, x_reg} + 11'(SIZE);
    assign y_end = {1'b0, y_reg} + 10'(SIZE);
    assign hit   = (col >= x_reg) && ({1'b0, col} < x_end) &&
                   (row >= y_reg) && ({1'b0, row} < y_end);

    // Registered hit flag and colour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cursor_here <= 1'b0;
            color_index <= 8'd0;
        end else begin
            cursor_here <= hit;
            color_index <= hit ? 8'(COLOR) : 8'd0;
        end
    end

    assign x_pos = x_reg;
    assign y_pos = y_reg;
    assign moved = moved_reg;

endmodule

// File: tb/tb_cursor_pointer.sv
// Directed bench for cursor_pointer. Instance a starts at 120/40 and
// instance b starts at 5/5 for the edge cases. Define CURSOR_WRAP_EN for the wrap build.
module tb_cursor_pointer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1;
    logic       up_b = 1'b1, left_b = 1'b1;
    logic [8:0] row = '0;
    logic [9:0] col = '0;

    logic       hit_a, moved_a, hit_b, moved_b;
    logic [7:0] ci_a, ci_b;
    logic [9:0] x_a, x_b;
    logic [8:0] y_a, y_b;

    int checks = 0;
    int errors = 0;
    int moved_seen = 0;
    logic mon_en = 1'b0;
    int tb_cnt = 0;

    always #5 clk = ~clk;

    cursor_pointer #(.X_INIT(120), .Y_INIT(40), .STEP(10), .SIZE(10), .X_MAX(640),
                     .Y_MAX(480), .TICK_DIV(4), .REPEAT_TICKS(3), .COLOR(5)) dut_a (
        .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
        .row(row), .col(col), .cursor_here(hit_a), .color_index(ci_a),
        .x_pos(x_a), .y_pos(y_a), .moved(moved_a));

    cursor_pointer #(.X_INIT(5), .Y_INIT(5), .STEP(10), .SIZE(10), .X_MAX(640),
                     .Y_MAX(480), .TICK_DIV(4), .REPEAT_TICKS(3), .COLOR(5)) dut_b (
        .clk(clk), .reset(reset), .up(up_b), .down(1'b1), .left(left_b), .right(1'b1),
        .row(row), .col(col), .cursor_here(hit_b), .color_index(ci_b),
        .x_pos(x_b), .y_pos(y_b), .moved(moved_b));

    // Expected tick phase: the tick edge follows the cycle in which this count is 3.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
    end

    // Counts moved pulses while the idle window is open.
    always @(negedge clk) begin
        if (mon_en && moved_a === 1'b1) moved_seen <= moved_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
        $display("check %-14s observed %0d expected %0d", tag, obs, exp_v);
    endtask

    // Advance to just after the next movement-tick edge.
    task automatic to_tick();
        @(negedge clk);
        while (tb_cnt != 3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [8:0] r, input logic [9:0] c);
        @(negedge clk);
        row = r;
        col = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_x", 32'(x_a), 120);
        check("rst_y", 32'(y_a), 40);
        check("rst_moved", 32'(moved_a), 0);
        check("rst_hit", 32'(hit_a), 0);
        check("rst_color", 32'(ci_a), 0);
        @(negedge clk);
        reset = 1'b0;

        // No buttons for 100 cycles
        mon_en = 1'b1;
        repeat (100) @(negedge clk);
        mon_en = 1'b0;
        check("idle_moved", 32'(moved_seen), 0);
        check("idle_x", 32'(x_a), 120);
        check("idle_y", 32'(y_a), 40);

        // Hit test at 120/40
        scan(9'd40, 10'd120);
        check("hit_tl", 32'(hit_a), 1);
        check("hit_tl_col", 32'(ci_a), 5);
        scan(9'd40, 10'd130);
        check("hit_right", 32'(hit_a), 0);
        check("hit_right_col", 32'(ci_a), 0);
        scan(9'd49, 10'd129);
        check("hit_br", 32'(hit_a), 1);
        scan(9'd39, 10'd120);
        check("hit_above", 32'(hit_a), 0);

        // Diagonal up+left
        to_tick();
        up = 1'b0; left = 1'b0;
        to_tick();
        check("diag_x", 32'(x_a), 110);
        check("diag_y", 32'(y_a), 30);
        check("diag_moved", 32'(moved_a), 1);
        up = 1'b1; left = 1'b1;
        to_tick();
        check("diag_rel_x", 32'(x_a), 110);

        // Opposing left+right
        left = 1'b0; right = 1'b0;
        to_tick();
        check("opp_x", 32'(x_a), 110);
        check("opp_y", 32'(y_a), 30);
        check("opp_moved", 32'(moved_a), 0);
        left = 1'b1; right = 1'b1;
        to_tick();

        // Hold right: move, two quiet ticks, then repeat every tick
        right = 1'b0;
        to_tick();
        check("hold_t1_x", 32'(x_a), 120);
        check("hold_t1_mv", 32'(moved_a), 1);
        to_tick();
        check("hold_t2_x", 32'(x_a), 120);
        check("hold_t2_mv", 32'(moved_a), 0);
        to_tick();
        check("hold_t3_x", 32'(x_a), 120);
        to_tick();
        check("hold_t4_x", 32'(x_a), 130);
        check("hold_t4_mv", 32'(moved_a), 1);
        to_tick();
        check("hold_t5_x", 32'(x_a), 140);
        repeat (6) to_tick();
        check("hold_200_x", 32'(x_a), 200);

        // Reset in REPEAT with right still held
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_x", 32'(x_a), 120);
        check("mid_rst_y", 32'(y_a), 40);
        check("mid_rst_mv", 32'(moved_a), 0);
        check("mid_rst_hit", 32'(hit_a), 0);
        @(negedge clk);
        reset = 1'b0;
        to_tick();
        check("post_t1_x", 32'(x_a), 130);
        check("post_t1_mv", 32'(moved_a), 1);
        to_tick();
        check("post_t2_x", 32'(x_a), 130);
        to_tick();
        check("post_t3_x", 32'(x_a), 130);
        to_tick();
        check("post_t4_x", 32'(x_a), 140);
        right = 1'b1;
        to_tick();

        // Edge behaviour on instance b from 5/5
        up_b = 1'b0; left_b = 1'b0;
        to_tick();
`ifdef CURSOR_WRAP_EN
        check("edge1_x", 32'(x_b), 626);
        check("edge1_y", 32'(y_b), 466);
`else
        check("edge1_x", 32'(x_b), 0);
        check("edge1_y", 32'(y_b), 0);
`endif
        check("edge1_mv", 32'(moved_b), 1);
        up_b = 1'b1; left_b = 1'b1;
        to_tick();
        left_b = 1'b0;
        to_tick();
`ifdef CURSOR_WRAP_EN
        check("edge2_x", 32'(x_b), 616);
        check("edge2_mv", 32'(moved_b), 1);
`else
        check("edge2_x", 32'(x_b), 0);
        check("edge2_mv", 32'(moved_b), 0);
`endif
        left_b = 1'b1;
        to_tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cursor_pointer.md
# cursor_pointer

Parametrised on-screen pointer controller for the VGA game display. Four active-low push buttons move a square pointer. The block adds diagonal motion, press-then-auto-repeat timing, and edge clamping or wrap-around. Each pixel clock it reports whether the current scan position (row, col) falls inside the pointer, together with the pointer colour index. It sits between the board button inputs and the pixel-colour mux, beside the sparkle overlay.

## Interface
- X_INIT, 120: x position after reset (pixels).
- Y_INIT, 40: y position after reset (pixels).
- STEP, 10: pixels moved per move event.
- SIZE, 10: pointer edge length in pixels.
- X_MAX, 640: screen width; legal x is 0..X_MAX-SIZE.
- Y_MAX, 480: screen height; legal y is 0..Y_MAX-SIZE.
- TICK_DIV, 2000000: clk cycles per movement tick.
- REPEAT_TICKS, 8: ticks of continuous hold before auto-repeat starts.
- COLOR, 5: colour index driven while the pointer is hit.
- clk  in  1  system/pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- up, down, left, right  in  1 each  raw active-low buttons, asynchronous to clk.
- row  in  9  current scan row.
- col  in  10  current scan column.
- cursor_here  out  1  registered hit flag for (row, col).
- color_index  out  8  COLOR when cursor_here is 1, else 0.
- x_pos  out  10  current pointer left edge.
- y_pos  out  9  current pointer top edge.
- moved  out  1  one-cycle pulse when the position changed.

## Operation
- Button synchroniser: each button passes through a 2-flop synchroniser and is then inverted to an active-high "pressed".
- Tick generator: a counter runs 0..TICK_DIV-1, then wraps to 0. `tick` is asserted for one cycle when the counter equals TICK_DIV-1.
- Axis decode, evaluated at each tick:
  - dx = -1 if only left is pressed; +1 if only right; 0 if neither or both.
  - dy follows the same rule with up (-1) and down (+1).
  - Both axes may move on the same tick (diagonal motion).
- Repeat FSM (all transitions happen only on tick; "any" means dx != 0 or dy != 0):
  - IDLE: if any, apply the move, clear rcnt, go to WAIT.
  - WAIT: if none, go to IDLE without moving. Otherwise increment rcnt without moving. When rcnt reaches REPEAT_TICKS, apply the move and go to REPEAT.
  - REPEAT: if any, apply the move every tick. If none, go to IDLE.
  - Changing which buttons are held while still holding at least one does not restart the FSM; the move always uses the current dx/dy.
- Move arithmetic:
  - Computed in 11-bit signed arithmetic per axis; the default is clamping.
  - If x < STEP and dx = -1, x becomes 0.
  - If x + STEP > X_MAX-SIZE and dx = +1, x becomes X_MAX-SIZE.
  - y follows the same rules with Y_MAX.
- moved: asserted the cycle after the tick if x or y changed value. A clamped move that leaves the position unchanged does not assert moved.
- Hit test:
  - Condition: col >= x, col < x+SIZE, row >= y, row < y+SIZE. Lower edges are inclusive, upper edges exclusive.
  - Sums are computed one bit wider than the operands.
  - The result is registered into cursor_here and color_index.

## Timing
- Reset values:
  - x_pos = X_INIT, y_pos = Y_INIT.
  - cursor_here = 0, color_index = 0, moved = 0.
  - Tick counter = 0, FSM = IDLE, rcnt = 0, synchronisers = released.
- Button to decision: a press is visible to the FSM 2 cycles after the raw edge. It takes effect at the first tick after that.
- Position: x_pos/y_pos update on the cycle after the tick (registered); moved is high in that same cycle.
- Hit latency: 1 cycle from row/col to cursor_here/color_index. The hit test uses the x/y register values current in the cycle row/col are sampled.
- Simultaneous opposing buttons: that axis holds, the other axis still moves, and the FSM treats the press as "any" only if the other axis is nonzero.
- Reset asserted mid-hold: all state returns immediately to reset values. After release, a still-held button moves at the first tick, as a fresh press.

## Configuration
- CURSOR_WRAP_EN defined: out-of-range moves wrap instead of clamping.
  - Left from x < STEP gives x + (X_MAX-SIZE+1) - STEP.
  - Right past X_MAX-SIZE gives x + STEP - (X_MAX-SIZE+1).
  - y wraps the same way with Y_MAX.
  - moved is asserted on every wrapped move.
- CURSOR_WRAP_EN undefined: clamping exactly as described in Operation.

## Test plan
Bench parameters: TICK_DIV=4, REPEAT_TICKS=3, STEP=10, SIZE=10, X_MAX=640, Y_MAX=480.
- Reset with X_INIT=120, Y_INIT=40, no buttons -> x_pos=120, y_pos=40, moved never asserts, and the position is still 120/40 after 100 cycles.
- Hold right continuously -> x_pos is 130 after the first tick. It then stays 130 for the next 2 ticks, becomes 140 on the 3rd tick, and then increases by 10 every tick.
- Hold up+left together from 120/40 -> after the first move x_pos=110, y_pos=30. Hold left+right only -> x_pos is unchanged and moved=0.
- From x=5, press left -> x_pos=0. Press again -> x_pos stays 0 with moved=0. With CURSOR_WRAP_EN defined, x=5 plus a left press gives x_pos=626.
- Pointer at 120/40, scan (row=40, col=120) -> cursor_here=1, color_index=5 one cycle later. (40, 130) -> 0. (49, 129) -> 1.
- Assert reset during REPEAT at x=200 -> x_pos=120 immediately. With right still held after release -> x_pos=130 at the first tick, then the full REPEAT_TICKS wait again.
